// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramped duty-cycle sequencer with period-aligned PWM output and fault lockout.
// Duty changes are committed only at period boundaries so no PWM period is ever truncated.
module pwm_ramp_ctrl #(
    parameter int PERIOD       = 10,
    parameter int DUTY_MAX     = 10,
    parameter int DUTY_W       = 4,
    parameter int DUTY_INIT    = 5,
    parameter int STEP_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_ready,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              fault,
    input  logic              fault_clr,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_out,
    output logic [DUTY_W-1:0] target_out,
    output logic              busy,
    output logic [1:0]        state_out
);
    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam int SW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
    localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DINIT = DUTY_W'(DUTY_INIT);
    localparam logic [CW-1:0]     CLAST = CW'(PERIOD - 1);
    localparam logic [SW-1:0]     SLAST = SW'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RAMP = 2'b01, FAULT = 2'b10} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     step_q, step_d;
    logic [DUTY_W-1:0] duty_q, duty_d, tgt_q, tgt_d;
    logic              pwm_q, pwm_d, ps_q, ps_d;
    logic              boundary;
    logic [DUTY_W-1:0] cmd_cap, tgt_n, duty_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            duty_q  <= DINIT;
            tgt_q   <= DINIT;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign boundary  = cnt_q == CLAST;
    assign cnt_d     = boundary ? '0 : cnt_q + 1'b1;
    assign ps_d      = boundary;
    // fault gates the output combinationally so the very next edge already drives low
    assign pwm_d     = !fault && state_q != FAULT && 32'(cnt_q) < 32'(duty_q);
    assign cmd_cap   = cmd_duty > DMAX ? DMAX : cmd_duty;
    assign tgt_n     = cmd_valid ? cmd_cap :
                       (inc_pulse && !dec_pulse) ? (tgt_q == DMAX ? tgt_q : tgt_q + 1'b1) :
                       (dec_pulse && !inc_pulse) ? (tgt_q == '0 ? tgt_q : tgt_q - 1'b1) : tgt_q;
    assign duty_step = tgt_q > duty_q ? duty_q + 1'b1 : duty_q - 1'b1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        if (fault) begin
            state_d = FAULT;
            duty_d  = '0;
            tgt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tgt_d = tgt_n;
                    if (tgt_q != duty_q) begin
                        state_d = RAMP;
                        step_d  = '0;
                    end
                end
                RAMP: begin
                    tgt_d = tgt_n;
                    if (tgt_q == duty_q) state_d = IDLE;
                    else if (boundary) begin
                        step_d = step_q == SLAST ? '0 : step_q + 1'b1;
                        if (step_q == SLAST) begin
                            duty_d  = duty_step;
                            state_d = duty_step == tgt_q ? IDLE : RAMP;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        state_d = IDLE;
                        duty_d  = '0;
                        tgt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_out      = pwm_q;
        period_start = ps_q;
        duty_out     = duty_q;
        target_out   = tgt_q;
        busy         = state_q == RAMP;
        cmd_ready    = state_q != FAULT;
        state_out    = state_q;
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scenario-driven bench; expected per-period duty values are queued when a
// command is issued and compared against the measured duty/high-count of each PWM period.
module tb_pwm_ramp_ctrl;
    localparam int DW = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0, inc_pulse = 1'b0, dec_pulse = 1'b0, fault = 1'b0, fault_clr = 1'b0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_ready, pwm_out, period_start, busy;
    logic [DW-1:0] duty_out, target_out;
    logic [1:0]    state_out;

    int checks = 0, failures = 0;
    int exp_q[$], obs_d[$], obs_h[$], obs_p[$];

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.PERIOD(10), .DUTY_MAX(10), .DUTY_W(DW), .DUTY_INIT(5), .STEP_PERIODS(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty), .cmd_ready(cmd_ready),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .fault(fault), .fault_clr(fault_clr),
        .pwm_out(pwm_out), .period_start(period_start), .duty_out(duty_out),
        .target_out(target_out), .busy(busy), .state_out(state_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        cmd_valid = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        fault_clr = 1'b0;
    endtask

    // Starts on a period_start sample; pulses driven beforehand last exactly one edge.
    task automatic run_periods(input int n);
        for (int k = 0; k < n; k++) begin
            int h = 0;
            obs_d.push_back(int'(duty_out));
            for (int i = 0; i < 10; i++) begin
                tick();
                clr_pulses();
                h += int'(pwm_out);
            end
            obs_h.push_back(h);
            obs_p.push_back(int'(period_start));
        end
    endtask

    task automatic sync_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            ok = period_start;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            ok = state_out == 2'b00 && duty_out == target_out;
        end
    endtask

    task automatic test_reset();
        int n = 0;
        #12;
        checks++;
        if ({duty_out, target_out, state_out, pwm_out, period_start, busy, cmd_ready} !== {4'd5, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values: duty=%0d tgt=%0d st=%0d pwm=%0d ps=%0d busy=%0d rdy=%0d required 5 5 0 0 0 0 1",
                     duty_out, target_out, state_out, pwm_out, period_start, busy, cmd_ready);
        end
        tick();
        rst = 1'b0;
        do begin tick(); n++; end while (!period_start && n < 20);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL first_period_start: edges=%0d required 10", n);
        end
        exp_q.push_back(5); exp_q.push_back(5);
        run_periods(2);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL idle_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
    endtask

    task automatic test_cmd_ramp();
        cmd_valid = 1'b1; cmd_duty = 4'd9;
        foreach (exp_q[i]) exp_q.delete(i);
        for (int v = 5; v <= 9; v++) begin exp_q.push_back(v); exp_q.push_back(v); end
        run_periods(1);
        checks++;
        if (busy !== 1'b1 || state_out !== 2'b01 || target_out !== 4'd9) begin
            failures++;
            $display("FAIL ramp_busy: busy=%0d st=%0d tgt=%0d required 1 1 9", busy, state_out, target_out);
        end
        run_periods(9);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL ramp_up_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
        checks++;
        if (busy !== 1'b0 || state_out !== 2'b00 || duty_out !== 4'd9) begin
            failures++;
            $display("FAIL ramp_done: busy=%0d st=%0d duty=%0d required 0 0 9", busy, state_out, duty_out);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        cmd_valid = 1'b1; cmd_duty = 4'd15;
        exp_q.push_back(9); exp_q.push_back(9); exp_q.push_back(10); exp_q.push_back(10);
        run_periods(4);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL sat_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
        checks++;
        if (target_out !== 4'd10) begin
            failures++;
            $display("FAIL cmd_clamp: tgt=%0d required 10", target_out);
        end
        for (int i = 0; i < 11; i++) begin
            dec_pulse = 1'b1;
            tick();
        end
        dec_pulse = 1'b0;
        checks++;
        if (target_out !== 4'd0) begin
            failures++;
            $display("FAIL dec_saturate: tgt=%0d required 0", target_out);
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1 || duty_out !== 4'd0) begin
            failures++;
            $display("FAIL ramp_down_done: ok=%0d duty=%0d required 1 0", ok, duty_out);
        end
        sync_ps(ok);
        exp_q.push_back(0); exp_q.push_back(0);
        run_periods(2);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL zero_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_t[5];
        exp_t = '{4'd10, 4'd10, 4'd10, 4'd3, 4'd2};
        for (int s = 0; s < 5; s++) begin
            cmd_valid = s == 0 || s == 3;
            cmd_duty  = s == 0 ? 4'd10 : 4'd3;
            inc_pulse = s == 1 || s == 2 || s == 3;
            dec_pulse = s == 2 || s == 4;
            tick();
            clr_pulses();
            checks++;
            if (target_out !== exp_t[s]) begin
                failures++;
                $display("FAIL simultaneous_%0d: tgt=%0d required %0d", s, target_out, exp_t[s]);
            end
        end
    endtask

    task automatic test_mid_ramp();
        bit ok;
        cmd_valid = 1'b1; cmd_duty = 4'd5;
        tick();
        clr_pulses();
        wait_idle(ok);
        sync_ps(ok);
        checks++;
        if (ok !== 1'b1 || duty_out !== 4'd5 || state_out !== 2'b00) begin
            failures++;
            $display("FAIL mid_setup: ok=%0d duty=%0d st=%0d required 1 5 0", ok, duty_out, state_out);
        end
        cmd_valid = 1'b1; cmd_duty = 4'd9;
        exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(6); exp_q.push_back(7);
        run_periods(5);
        cmd_valid = 1'b1; cmd_duty = 4'd4;
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(6);
        exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(4);
        run_periods(6);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL redirect_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
        checks++;
        if (state_out !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL redirect_done: st=%0d busy=%0d required 0 0", state_out, busy);
        end
    endtask

    task automatic test_fault();
        bit ok;
        int h = 0;
        cmd_valid = 1'b1; cmd_duty = 4'd9;
        run_periods(2);
        exp_q.push_back(4); exp_q.push_back(4);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), hh = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || hh !== e || p !== 1) begin
                failures++;
                $display("FAIL prefault_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, hh, p, e, e);
            end
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pwm_out !== 1'b1 || duty_out !== 4'd5) begin
            failures++;
            $display("FAIL prefault_pwm: pwm=%0d duty=%0d required 1 5", pwm_out, duty_out);
        end
        fault = 1'b1;
        tick();
        checks++;
        if ({pwm_out, cmd_ready, duty_out, target_out, state_out, busy} !== {1'b0, 1'b0, 4'd0, 4'd0, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL fault_entry: pwm=%0d rdy=%0d duty=%0d tgt=%0d st=%0d busy=%0d required 0 0 0 0 2 0",
                     pwm_out, cmd_ready, duty_out, target_out, state_out, busy);
        end
        fault_clr = 1'b1;
        tick();
        clr_pulses();
        checks++;
        if (state_out !== 2'b10) begin
            failures++;
            $display("FAIL clr_while_fault: st=%0d required 2", state_out);
        end
        cmd_valid = 1'b1; cmd_duty = 4'd7; inc_pulse = 1'b1;
        tick();
        clr_pulses();
        checks++;
        if (target_out !== 4'd0 || duty_out !== 4'd0) begin
            failures++;
            $display("FAIL fault_ignores_cmd: tgt=%0d duty=%0d required 0 0", target_out, duty_out);
        end
        fault = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            h += int'(pwm_out);
        end
        checks++;
        if (h !== 0 || state_out !== 2'b10) begin
            failures++;
            $display("FAIL fault_hold: high=%0d st=%0d required 0 2", h, state_out);
        end
        fault_clr = 1'b1;
        tick();
        clr_pulses();
        checks++;
        if (state_out !== 2'b00 || duty_out !== 4'd0 || target_out !== 4'd0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fault_clear: st=%0d duty=%0d tgt=%0d rdy=%0d required 0 0 0 1", state_out, duty_out, target_out, cmd_ready);
        end
        sync_ps(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL post_fault_sync: period_start seen=%0d required 1", ok);
        end
        cmd_valid = 1'b1; cmd_duty = 4'd2;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
        run_periods(5);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), hh = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || hh !== e || p !== 1) begin
                failures++;
                $display("FAIL post_fault_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, hh, p, e, e);
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        tick();
        checks++;
        if (pwm_out !== 1'b1 || duty_out !== 4'd2) begin
            failures++;
            $display("FAIL prereset_state: pwm=%0d duty=%0d required 1 2", pwm_out, duty_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({duty_out, target_out, state_out, pwm_out, period_start} !== {4'd5, 4'd5, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: duty=%0d tgt=%0d st=%0d pwm=%0d ps=%0d required 5 5 0 0 0",
                     duty_out, target_out, state_out, pwm_out, period_start);
        end
        tick();
        tick();
        rst = 1'b0;
        do begin tick(); n++; end while (!period_start && n < 20);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL reset_period_start: edges=%0d required 10", n);
        end
        exp_q.push_back(5);
        run_periods(1);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front(), d = obs_d.pop_front(), h = obs_h.pop_front(), p = obs_p.pop_front();
            checks++;
            if (d !== e || h !== e || p !== 1) begin
                failures++;
                $display("FAIL post_reset_period: duty=%0d high=%0d ps=%0d required duty=%0d high=%0d ps=1", d, h, p, e, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd_ramp();
        test_saturate();
        test_simultaneous();
        test_mid_ramp();
        test_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
